gd_iteration_controller: RTL and testbench

- Top-level sequencer for the 4-parameter (a,b,c,d) Q8.8 gradient-descent engine.
- Each iteration it requests gradients from the gradient unit, applies a shift-based learning-rate update with saturation, and drives one-cycle convergence checks into the convergence checker.
- Terminates on convergence, iteration limit, gradient timeout or abort, and reports final parameters and a status code.

---
 rtl/gd_iteration_controller.sv | 207 ++++++++++++++++++++
 tb/tb_gd_iteration_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gd_iteration_controller.sv
// Iteration sequencer for the 4-parameter Q8.8 gradient-descent engine:
// requests gradients, applies a saturating shift-based update, and triggers convergence checks.
module gd_iteration_controller #(
  parameter int MAX_ITER     = 50,
  parameter int ITER_W       = $clog2(MAX_ITER + 1),
  parameter int LR_SHIFT     = 4,
  parameter int GRAD_TIMEOUT = 255,
  parameter int USE_STEP     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       a_init,
  input  logic [15:0]       b_init,
  input  logic [15:0]       c_init,
  input  logic [15:0]       d_init,
  output logic              grad_req,
  input  logic              grad_ack,
  input  logic [15:0]       grad_a,
  input  logic [15:0]       grad_b,
  input  logic [15:0]       grad_c,
  input  logic [15:0]       grad_d,
  output logic [15:0]       a_out,
  output logic [15:0]       b_out,
  output logic [15:0]       c_out,
  output logic [15:0]       d_out,
  output logic [15:0]       a_step,
  output logic [15:0]       b_step,
  output logic [15:0]       c_step,
  output logic [15:0]       d_step,
  output logic              check_enable,
  output logic              use_step_method,
  input  logic              converged_in,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRAD, S_UPDATE, S_CHECK, S_WAIT_CONV, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_CONVERGED = 2'b00,
    ST_MAX_ITER  = 2'b01,
    ST_TIMEOUT   = 2'b10,
    ST_ABORTED   = 2'b11
  } status_t;

  state_t              state_q, state_d;
  status_t             status_q, status_d;
  logic [3:0][15:0]    param_q, step_q, grad_q;
  logic [3:0][15:0]    param_new, step_new;
  logic [ITER_W-1:0]   iter_q;
  logic [15:0]         tmo_q;
  logic                load, capture, commit, tmo_inc, status_we;

  // Step is the negated arithmetic right shift; -(x >>> n) cannot overflow for n >= 1.
  function automatic logic [15:0] calc_step(input logic signed [15:0] g);
    logic signed [15:0] shifted;
    shifted = g >>> LR_SHIFT;
    return -shifted;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] p, input logic [15:0] s);
    logic [16:0] sum;
    sum = {p[15], p} + {s[15], s};
    if (sum[16] != sum[15]) return sum[16] ? 16'h8000 : 16'h7FFF;
    return sum[15:0];
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      step_new[i]  = calc_step(grad_q[i]);
      param_new[i] = sat_add(param_q[i], step_new[i]);
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    status_we    = 1'b0;
    load         = 1'b0;
    capture      = 1'b0;
    commit       = 1'b0;
    tmo_inc      = 1'b0;
    grad_req     = 1'b0;
    check_enable = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_GRAD;
        end
      end
      S_GRAD: begin
        if (abort) begin
          status_d  = ST_ABORTED;
          status_we = 1'b1;
          state_d   = S_DONE;
        end else begin
          grad_req = 1'b1;
          if (grad_ack) begin
            capture = 1'b1;
            state_d = S_UPDATE;
          end else begin
            tmo_inc = 1'b1;
            if (tmo_q == 16'(GRAD_TIMEOUT - 1)) begin
              status_d  = ST_TIMEOUT;
              status_we = 1'b1;
              state_d   = S_DONE;
            end
          end
        end
      end
      S_UPDATE: begin
        if (abort) begin
          status_d  = ST_ABORTED;
          status_we = 1'b1;
          state_d   = S_DONE;
        end else begin
          commit  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          status_d  = ST_ABORTED;
          status_we = 1'b1;
          state_d   = S_DONE;
        end else begin
          check_enable = 1'b1;
          state_d      = S_WAIT_CONV;
        end
      end
      S_WAIT_CONV: begin
        status_we = 1'b1;
        if (abort) begin
          status_d = ST_ABORTED;
          state_d  = S_DONE;
        end else if (converged_in) begin
          status_d = ST_CONVERGED;
          state_d  = S_DONE;
        end else if (iter_q == ITER_W'(MAX_ITER)) begin
          status_d = ST_MAX_ITER;
          state_d  = S_DONE;
        end else begin
          status_we = 1'b0;
          state_d   = S_GRAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      status_q <= ST_CONVERGED;
      param_q  <= '0;
      step_q   <= '0;
      grad_q   <= '0;
      iter_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (status_we) status_q <= status_d;
      if (load) begin
        param_q  <= {d_init, c_init, b_init, a_init};
        step_q   <= '0;
        iter_q   <= '0;
        tmo_q    <= '0;
        status_q <= ST_CONVERGED;
      end
      if (tmo_inc) tmo_q <= tmo_q + 16'd1;
      if (capture) begin
        grad_q <= {grad_d, grad_c, grad_b, grad_a};
        tmo_q  <= '0;
      end
      if (commit) begin
        param_q <= param_new;
        step_q  <= step_new;
        iter_q  <= iter_q + ITER_W'(1);
      end
    end
  end

  assign a_out           = param_q[0];
  assign b_out           = param_q[1];
  assign c_out           = param_q[2];
  assign d_out           = param_q[3];
  assign a_step          = step_q[0];
  assign b_step          = step_q[1];
  assign c_step          = step_q[2];
  assign d_step          = step_q[3];
  assign iter_count      = iter_q;
  assign status          = status_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign use_step_method = 1'(USE_STEP);

endmodule

// File: tb/tb_gd_iteration_controller.sv
// Scoreboard bench for gd_iteration_controller: each run pushes its expected
// end-of-run record; a monitor pops and compares on every done pulse.
module tb_gd_iteration_controller;
  localparam int MAX_ITER = 50;
  localparam int GT       = 8;
  localparam int LR       = 4;
  localparam int ITER_W   = $clog2(MAX_ITER + 1);

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] a_init = '0, b_init = '0, c_init = '0, d_init = '0;
  logic [15:0] grad_a = '0, grad_b = '0, grad_c = '0, grad_d = '0;
  logic grad_ack = 1'b0, converged_in = 1'b0;
  logic grad_req, check_enable, use_step_method, busy, done;
  logic [15:0] a_out, b_out, c_out, d_out, a_step, b_step, c_step, d_step;
  logic [ITER_W-1:0] iter_count;
  logic [1:0] status;

  always #5 clk = ~clk;

  gd_iteration_controller #(.MAX_ITER(MAX_ITER), .LR_SHIFT(LR), .GRAD_TIMEOUT(GT), .USE_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
    .grad_req(grad_req), .grad_ack(grad_ack),
    .grad_a(grad_a), .grad_b(grad_b), .grad_c(grad_c), .grad_d(grad_d),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
    .a_step(a_step), .b_step(b_step), .c_step(c_step), .d_step(d_step),
    .check_enable(check_enable), .use_step_method(use_step_method),
    .converged_in(converged_in), .iter_count(iter_count),
    .busy(busy), .done(done), .status(status)
  );

  typedef struct {
    logic [3:0][15:0] p;   // expected a..d _out (index 0 = a)
    logic [3:0][15:0] s;   // expected a..d _step
    int iter;
    int stat;
    int cycles;            // start cycle through done cycle, inclusive
    int greq;              // cycles with grad_req high
    int checks;            // check_enable pulses
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0, n_fail = 0;
  int run_cycles = 0, greq_cycles = 0, chk_pulses = 0, done_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: tracks per-run activity and compares against the scoreboard on done.
  always @(negedge clk) begin
    if (start && !busy && rst_n) begin
      run_cycles = 1; greq_cycles = 0; chk_pulses = 0;
    end else if (busy) begin
      run_cycles++;
      if (grad_req) greq_cycles++;
      if (check_enable) chk_pulses++;
    end
    if (done) begin
      done_count++;
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done pulse expected none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("a_out",  a_out,  e.p[0]); check("b_out",  b_out,  e.p[1]);
        check("c_out",  c_out,  e.p[2]); check("d_out",  d_out,  e.p[3]);
        check("a_step", a_step, e.s[0]); check("b_step", b_step, e.s[1]);
        check("c_step", c_step, e.s[2]); check("d_step", d_step, e.s[3]);
        check("iter_count", iter_count, e.iter);
        check("status", status, e.stat);
        check("run_cycles", run_cycles, e.cycles);
        check("grad_req_cycles", greq_cycles, e.greq);
        check("check_pulses", chk_pulses, e.checks);
        check("busy_in_done", busy, 1);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_a_out"}, a_out, 0);   check({tag, "_d_out"}, d_out, 0);
    check({tag, "_a_step"}, a_step, 0); check({tag, "_iter"}, iter_count, 0);
    check({tag, "_status"}, status, 0); check({tag, "_grad_req"}, grad_req, 0);
    check({tag, "_check_en"}, check_enable, 0);
    check({tag, "_busy"}, busy, 0);     check({tag, "_done"}, done, 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_count == d0 && n < 1000) begin
      @(posedge clk); n++;
    end
    if (done_count == d0) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic set_vec(input logic [15:0] ai, bi, ci, di, ga, gb, gc, gd);
    a_init = ai; b_init = bi; c_init = ci; d_init = di;
    grad_a = ga; grad_b = gb; grad_c = gc; grad_d = gd;
  endtask

  task automatic run(input exp_t e);
    int d0;
    d0 = done_count;
    sb_q.push_back(e);
    pulse_start();
    wait_done(d0);
  endtask

  initial begin
    exp_t e;
    int d0, n;

    #1 check_zero("reset");
    check("use_step_method", use_step_method, 1);
    #20 rst_n = 1'b1;

    // Basic update, converged after one iteration.
    grad_ack = 1'b1; converged_in = 1'b1;
    set_vec(16'h0400, 16'hFC00, 16'h0000, 16'h0010, 16'h0800, 16'hF000, 16'h0007, 16'hFFFF);
    e.p = {16'h0011, 16'h0000, 16'hFD00, 16'h0380};
    e.s = {16'h0001, 16'h0000, 16'h0100, 16'hFF80};
    e.iter = 1; e.stat = 0; e.cycles = 6; e.greq = 1; e.checks = 1;
    run(e);

    // Saturation both directions, plus extremes with zero gradient.
    set_vec(16'h7F00, 16'h8100, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FF0, 16'h0000, 16'h0000);
    e.p = {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    e.s = {16'h0000, 16'h0000, 16'hF801, 16'h0800};
    e.iter = 1; e.stat = 0; e.cycles = 6; e.greq = 1; e.checks = 1;
    run(e);

    // Max-iter with zero gradients.
    converged_in = 1'b0;
    set_vec(16'h1234, 16'hEDCB, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    e.p = {16'hFFFF, 16'h0001, 16'hEDCB, 16'h1234};
    e.s = '0;
    e.iter = MAX_ITER; e.stat = 1; e.cycles = 2 + 4 * MAX_ITER; e.greq = MAX_ITER; e.checks = MAX_ITER;
    run(e);

    // Gradient timeout: no ack ever.
    grad_ack = 1'b0;
    set_vec(16'h0A0A, 16'hB0B0, 16'h0C0C, 16'hD0D0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    e.p = {16'hD0D0, 16'h0C0C, 16'hB0B0, 16'h0A0A};
    e.s = '0;
    e.iter = 0; e.stat = 2; e.cycles = GT + 2; e.greq = GT; e.checks = 0;
    run(e);

    // Abort coinciding with grad_ack in iteration 3; start during busy ignored.
    grad_ack = 1'b1;
    set_vec(16'h0100, 16'h0000, 16'h0200, 16'h0000, 16'h0010, 16'hFFF0, 16'h0100, 16'h0000);
    e.p = {16'h0000, 16'h01E0, 16'h0002, 16'h00FE};
    e.s = {16'h0000, 16'hFFF0, 16'h0001, 16'hFFFF};
    e.iter = 2; e.stat = 3; e.cycles = 11; e.greq = 2; e.checks = 2;
    d0 = done_count;
    sb_q.push_back(e);
    pulse_start();
    @(posedge clk); #1 a_init = 16'h5555; start = 1'b1;
    @(posedge clk); #1 a_init = 16'h0100; start = 1'b0;
    n = 0;
    while (!(grad_req && iter_count == 2) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("abort_window_found", (grad_req && iter_count == 2), 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(d0);

    // Async reset while in WAIT_CONV: everything clears, no done.
    set_vec(16'h0300, 16'h0300, 16'h0300, 16'h0300, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    d0 = done_count;
    pulse_start();
    n = 0;
    while (!check_enable && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    check("pre_reset_a_out", a_out, 16'h02F0);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1 check_zero("midreset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("no_done_on_reset", done_count, d0);

    // Fresh run after reset.
    converged_in = 1'b1;
    set_vec(16'h0050, 16'hFF00, 16'h0000, 16'h0001, 16'hFFC0, 16'h0020, 16'h0000, 16'h0000);
    e.p = {16'h0001, 16'h0000, 16'hFEFE, 16'h0054};
    e.s = {16'h0000, 16'h0000, 16'hFFFE, 16'h0004};
    e.iter = 1; e.stat = 0; e.cycles = 6; e.greq = 1; e.checks = 1;
    run(e);

    check("done_pulses_total", done_count, 6);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation stall expected completion");
    $fatal(1, "global timeout");
  end
endmodule
